// File: rtl/draw_pkg.sv
// Shared constants for the draw pipeline.
//   DRW_CMD_W   : command word width
//   RBUF_ADDR_W : command buffer RAM address width
//   RBUF_CNT_W  : command buffer occupancy counter width
//   REQ_CNT_W   : command-request threshold width
//   OS_*        : command buffer output-stage state encoding
package draw_pkg;

  localparam int unsigned DRW_CMD_W   = 32;
  localparam int unsigned RBUF_ADDR_W = 10;
  localparam int unsigned RBUF_CNT_W  = 11;
  localparam int unsigned REQ_CNT_W   = 10;

  typedef logic [1:0] os_state_t;

  localparam os_state_t OS_IDLE  = 2'd0;
  localparam os_state_t OS_FETCH = 2'd1;
  localparam os_state_t OS_VALID = 2'd2;

endpackage

// File: rtl/draw_cmdbuf_ram.sv
// Simple dual-port RAM backing the draw command buffer.
// Synchronous write, registered (1-cycle) read, array is not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   re    : read enable
//   raddr : read address
//   rdata : read data, valid the cycle after re
module draw_cmdbuf_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/draw_cmdbuf.sv
// Draw-command receive buffer: queues CMD words from the register block in a RAM FIFO,
// presents the head word to the command decoder and drives a hysteresis request line.
//   CLK, RST      : clock, synchronous active-high reset
//   INIT          : soft clear, same effect as RST
//   BUF_WR, CMD   : push strobe and word
//   DEC_RD        : decoder pop, honoured only while DEC_VALID=1
//   DEC_CMD       : head word, DEC_VALID marks it valid
//   RBUF_FULL     : occupancy == DEPTH
//   RBUF_EMPTY    : occupancy == 0
//   RBUF_WCOUNT   : words held, RAM plus output stage
//   REQ_ON_COUNT  : CMD_REQ asserts at or below this occupancy
//   REQ_OFF_COUNT : CMD_REQ releases at or above this occupancy; 0 disables
//   CMD_REQ       : request for more commands
//   OVF_ERR       : sticky, a push was dropped while full
module draw_cmdbuf
  import draw_pkg::*;
#(
  parameter int unsigned DATA_W = DRW_CMD_W,
  parameter int unsigned ADDR_W = RBUF_ADDR_W,
  parameter int unsigned CNT_W  = RBUF_CNT_W,
  parameter int unsigned THR_W  = REQ_CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              INIT,
  input  logic              BUF_WR,
  input  logic [DATA_W-1:0] CMD,
  input  logic              DEC_RD,
  output logic [DATA_W-1:0] DEC_CMD,
  output logic              DEC_VALID,
  output logic              RBUF_FULL,
  output logic              RBUF_EMPTY,
  output logic [CNT_W-1:0]  RBUF_WCOUNT,
  input  logic [THR_W-1:0]  REQ_ON_COUNT,
  input  logic [THR_W-1:0]  REQ_OFF_COUNT,
  output logic              CMD_REQ,
  output logic              OVF_ERR
);

  localparam int unsigned     DEPTH     = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic              clr;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_next;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_next;
  logic [CNT_W-1:0]  count, count_next;
  os_state_t         state, state_next;
  logic [DATA_W-1:0] cmd_reg, cmd_next;
  logic              req, req_next;
  logic              ovf, ovf_next;
  logic              push_ok, pop_ok;
  logic              ram_has_data;
  logic              rd_en;
  logic [DATA_W-1:0] ram_rdata;
  logic [CNT_W-1:0]  on_thr, off_thr;

  assign clr = RST | INIT;

  // Full/empty come from the registered count, so a push while full is dropped
  // even if a pop retires a word on the same edge.
  assign RBUF_FULL   = (count == DEPTH_CNT);
  assign RBUF_EMPTY  = (count == '0);
  assign RBUF_WCOUNT = count;
  assign DEC_VALID   = (state == OS_VALID);
  assign DEC_CMD     = cmd_reg;
  assign CMD_REQ     = req;
  assign OVF_ERR     = ovf;

  assign push_ok = BUF_WR & ~RBUF_FULL;
  assign pop_ok  = DEC_RD & DEC_VALID;

  // The count includes the word owned by the output stage (in flight or presented),
  // so the RAM only holds unread words when count exceeds that.
  always_comb begin
    ram_has_data = 1'b0;
    if (state == OS_IDLE) begin
      ram_has_data = (count != '0);
    end else begin
      ram_has_data = (count > CNT_W'(1));
    end
  end

  // Output stage: one read in flight at a time, giving one word per two cycles.
  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    cmd_next   = cmd_reg;
    unique case (state)
      OS_IDLE: begin
        if (ram_has_data) begin
          rd_en      = 1'b1;
          state_next = OS_FETCH;
        end
      end
      OS_FETCH: begin
        cmd_next   = ram_rdata;
        state_next = OS_VALID;
      end
      OS_VALID: begin
        if (DEC_RD) begin
          if (ram_has_data) begin
            rd_en      = 1'b1;
            state_next = OS_FETCH;
          end else begin
            state_next = OS_IDLE;
          end
        end
      end
      default: begin
        state_next = OS_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    count_next  = count;
    ovf_next    = ovf;
    if (push_ok) begin
      wr_ptr_next = wr_ptr + ADDR_W'(1);
    end
    if (rd_en) begin
      rd_ptr_next = rd_ptr + ADDR_W'(1);
    end
    if (BUF_WR && RBUF_FULL) begin
      ovf_next = 1'b1;
    end
    if (push_ok && !pop_ok) begin
      count_next = count + CNT_W'(1);
    end else if (!push_ok && pop_ok) begin
      count_next = count - CNT_W'(1);
    end
  end

  // Request hysteresis against the registered count, thresholds zero-extended.
  assign on_thr  = CNT_W'(REQ_ON_COUNT);
  assign off_thr = CNT_W'(REQ_OFF_COUNT);

  always_comb begin
    req_next = req;
    if (REQ_OFF_COUNT == '0) begin
      req_next = 1'b0;
    end else if (!req && (count <= on_thr)) begin
      req_next = 1'b1;
    end else if (req && (count >= off_thr)) begin
      req_next = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      state   <= OS_IDLE;
      cmd_reg <= '0;
      req     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_next;
      rd_ptr  <= rd_ptr_next;
      count   <= count_next;
      state   <= state_next;
      cmd_reg <= cmd_next;
      req     <= req_next;
      ovf     <= ovf_next;
    end
  end

  // A read issued on a clearing edge is harmless: the FSM returns to idle and
  // never consumes the RAM output.
  draw_cmdbuf_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (CLK),
    .we   (push_ok & ~clr),
    .waddr(wr_ptr),
    .wdata(CMD),
    .re   (rd_en & ~clr),
    .raddr(rd_ptr),
    .rdata(ram_rdata)
  );

endmodule

// File: doc/draw_cmdbuf.md
Name: draw_cmdbuf

Overview:
Draw-command receive buffer, directly downstream of the draw register block.
- Captures each 32-bit CMD word on the BUF_WR pulse and queues it in a 1024-entry FIFO.
- Presents the head word to the command decoder with a valid/pop handshake.
- Returns RBUF_FULL, RBUF_EMPTY and RBUF_WCOUNT to the register block for status readback.
- Drives a hysteresis-controlled command-request line (CMD_REQ) from the REQ_ON_COUNT/REQ_OFF_COUNT thresholds.

Parameters:
DATA_W, 32, command word width
ADDR_W, 10, RAM address width; capacity DEPTH = 2**ADDR_W = 1024 words
CNT_W, 11, occupancy counter width (ADDR_W+1)
THR_W, 10, request threshold width

Ports:
CLK  in  1  clock; the only clock
RST  in  1  reset
INIT  in  1  soft clear, same effect as RST
BUF_WR  in  1  push strobe, one word per high cycle
CMD  in  DATA_W  word pushed on BUF_WR
DEC_RD  in  1  decoder pop; consumes DEC_CMD when DEC_VALID=1
DEC_CMD  out  DATA_W  head word
DEC_VALID  out  1  DEC_CMD holds a valid word
RBUF_FULL  out  1  occupancy == DEPTH
RBUF_EMPTY  out  1  occupancy == 0
RBUF_WCOUNT  out  CNT_W  words held (RAM plus output stage)
REQ_ON_COUNT  in  THR_W  request-assert threshold
REQ_OFF_COUNT  in  THR_W  request-release threshold; 0 disables requests
CMD_REQ  out  1  request for more commands
OVF_ERR  out  1  sticky: a push was dropped because the buffer was full

Interface: one clock; reset is synchronous and active-high. Clock port is CLK, reset port is RST.

Behaviour:
- Reset (RST=1 or INIT=1 at a CLK edge), with priority over all other inputs:
  - pointers and count cleared
  - output stage goes to OS_IDLE
  - DEC_VALID=0, DEC_CMD=0, RBUF_WCOUNT=0, RBUF_EMPTY=1, RBUF_FULL=0, CMD_REQ=0, OVF_ERR=0
  - a reset mid-operation discards all held words, including any RAM read in flight
- Push:
  - BUF_WR=1 and RBUF_FULL=0 (registered value) writes CMD at wr_ptr and increments wr_ptr modulo DEPTH.
  - BUF_WR=1 with RBUF_FULL=1 drops the word and sets OVF_ERR. This holds even if a pop happens in the same cycle.
- Count: RBUF_WCOUNT is registered.
  - +1 on an accepted push; -1 on an accepted pop (DEC_RD and DEC_VALID).
  - Push and pop in the same cycle: count unchanged.
  - RBUF_FULL = (count==DEPTH) and RBUF_EMPTY = (count==0), both taken from the registered count.
- Output stage FSM. RAM read is synchronous, 1-cycle. "RAM holds data" means words exist beyond the output stage.
  - OS_IDLE: if RAM holds data, issue a read at rd_ptr, rd_ptr+1, go to OS_FETCH.
  - OS_FETCH: load DEC_CMD from the RAM output, DEC_VALID=1, go to OS_VALID.
  - OS_VALID with DEC_RD:
    - if RAM holds data: issue the next read, go to OS_FETCH (DEC_VALID=0 for one cycle)
    - otherwise go to OS_IDLE
  - OS_VALID without DEC_RD: hold DEC_CMD.
  - DEC_RD while DEC_VALID=0 is ignored; no underflow, no state change.
- Timing:
  - A push into an empty buffer at edge N gives DEC_VALID=1 after edge N+2.
  - Sustained pop rate is 1 word per 2 cycles.
  - A write and a read at the same RAM address in one cycle cannot occur: reads only target words already committed.
- Request hysteresis (CMD_REQ registered). Comparisons are unsigned, with thresholds zero-extended to CNT_W.
  - REQ_OFF_COUNT==0: CMD_REQ=0 (disabled).
  - CMD_REQ=0 and WCOUNT <= REQ_ON_COUNT: set.
  - CMD_REQ=1 and WCOUNT >= REQ_OFF_COUNT: clear.
  - If REQ_ON_COUNT >= REQ_OFF_COUNT, CMD_REQ toggles each cycle while both conditions hold. This is accepted as a software misconfiguration.
  - Threshold changes take effect the cycle after they change.
- Wrap-around: pointers wrap 1023 -> 0 with no effect on count.

Decomposition:
- Shared package draw_pkg holds:
  - DRW_CMD_W=32, RBUF_ADDR_W=10, RBUF_CNT_W=11, REQ_CNT_W=10
  - output-stage state encoding OS_IDLE=0, OS_FETCH=1, OS_VALID=2
- One sub-module: draw_cmdbuf_ram, a simple dual-port RAM, DEPTH x DATA_W, synchronous write and registered read, no reset on the array.
- Pointers, count, FSM, request logic and error flag stay in draw_cmdbuf.

Test Plan:
- Reset then push 0x11223344 -> DEC_VALID=1 and DEC_CMD=0x11223344 two edges after the push; WCOUNT=1; RBUF_EMPTY=0; pop -> WCOUNT=0, RBUF_EMPTY=1, DEC_VALID=0.
- Push 1024 words 0..1023 with no pops -> RBUF_FULL=1, WCOUNT=1024; push 0xDEAD -> dropped, OVF_ERR=1; pop all -> 0..1023 in order, 0xDEAD absent.
- Fill to 1000, then push and pop together every other cycle across the pointer wrap -> WCOUNT stable, data in order, OVF_ERR=0.
- REQ_ON=4, REQ_OFF=16, fill from empty -> CMD_REQ=1 at WCOUNT 0..15, drops the cycle after WCOUNT reaches 16; drain -> reasserts the cycle after WCOUNT reaches 4.
- REQ_OFF=0 with any REQ_ON and empty buffer -> CMD_REQ stays 0.
- INIT pulse while OS_FETCH is active with 10 words held and OVF_ERR=1 -> next cycle all outputs at reset values; the next push is delivered after 2 edges.
